// File: rtl/memory_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory port arbiter.
// The arbiter takes the slave view; the environment (fetch, memory stage, memory) takes master.
interface memory_port_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     fetch_request;
  logic [ADDRESS_WIDTH-1:0] fetch_address;
  logic                     fetch_done;
  logic [DATA_WIDTH-1:0]    fetch_data;

  logic                     data_read;
  logic                     data_write;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [DATA_WIDTH-1:0]    data_write_data;
  logic                     data_done;
  logic [DATA_WIDTH-1:0]    data_read_data;

  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_read;
  logic                     mem_write;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic [DATA_WIDTH-1:0]    mem_read_data;
  logic                     mem_wait;

  modport slave (
    input  fetch_request, fetch_address,
    input  data_read, data_write, data_address, data_write_data,
    input  mem_read_data, mem_wait,
    output fetch_done, fetch_data, data_done, data_read_data,
    output mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output fetch_request, fetch_address,
    output data_read, data_write, data_address, data_write_data,
    output mem_read_data, mem_wait,
    input  fetch_done, fetch_data, data_done, data_read_data,
    input  mem_address, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and data ld/store/cx accesses,
// with data priority, a fetch anti-starvation limit and an uninterruptible exchange.
module memory_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
  input logic                  clock,
  input logic                  reset,
  memory_port_arbiter_if.slave bus
);
  localparam int unsigned STARVE_WIDTH = $clog2(FETCH_STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(FETCH_STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_RD,
    S_DATA_RD,
    S_DATA_WR,
    S_XCHG_RD,
    S_XCHG_WR
  } state_t;

  state_t                   r_state,          w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mem_address,    w_mem_address_nxt;
  logic [DATA_WIDTH-1:0]    r_mem_write_data, w_mem_write_data_nxt;
  logic                     r_mem_read,       w_mem_read_nxt;
  logic                     r_mem_write,      w_mem_write_nxt;
  logic [STARVE_WIDTH-1:0]  r_starve,         w_starve_nxt;
  logic [DATA_WIDTH-1:0]    r_xchg,           w_xchg_nxt;

  logic w_complete;
  logic w_arb;
  logic w_fetch_req;
  logic w_data_req;
  logic w_grant_fetch;
  logic w_grant_data;

  // Arbitration happens in Idle or when any phase but the exchange read completes;
  // the requester finishing at that edge is masked so it cannot be re-granted.
  assign w_complete    = (r_state != S_IDLE) && !bus.mem_wait;
  assign w_arb         = (r_state == S_IDLE) || (w_complete && (r_state != S_XCHG_RD));
  assign w_fetch_req   = bus.fetch_request && (r_state != S_FETCH_RD);
  assign w_data_req    = (bus.data_read || bus.data_write) &&
                         !(r_state inside {S_DATA_RD, S_DATA_WR, S_XCHG_WR});
  assign w_grant_fetch = w_arb && w_fetch_req && (!w_data_req || (r_starve == STARVE_MAX));
  assign w_grant_data  = w_arb && w_data_req && !w_grant_fetch;

  always_comb begin
    w_state_nxt          = r_state;
    w_mem_address_nxt    = r_mem_address;
    w_mem_write_data_nxt = r_mem_write_data;
    w_mem_read_nxt       = r_mem_read;
    w_mem_write_nxt      = r_mem_write;
    w_starve_nxt         = r_starve;
    w_xchg_nxt           = r_xchg;

    if (w_grant_fetch) begin
      w_state_nxt       = S_FETCH_RD;
      w_mem_address_nxt = bus.fetch_address;
      w_mem_read_nxt    = 1'b1;
      w_mem_write_nxt   = 1'b0;
      w_starve_nxt      = '0;
    end else if (w_grant_data) begin
      w_mem_address_nxt = bus.data_address;
      w_mem_read_nxt    = bus.data_read;
      w_mem_write_nxt   = bus.data_write && !bus.data_read;
      if (bus.data_write) begin
        w_mem_write_data_nxt = bus.data_write_data;
      end
      if (bus.data_read && bus.data_write) begin
        w_state_nxt = S_XCHG_RD;
      end else if (bus.data_read) begin
        w_state_nxt = S_DATA_RD;
      end else begin
        w_state_nxt = S_DATA_WR;
      end
      if (bus.fetch_request && (r_starve != STARVE_MAX)) begin
        w_starve_nxt = r_starve + STARVE_WIDTH'(1);
      end
    end else if (w_arb) begin
      w_state_nxt     = S_IDLE;
      w_mem_read_nxt  = 1'b0;
      w_mem_write_nxt = 1'b0;
    end else if ((r_state == S_XCHG_RD) && w_complete) begin
      // Exchange turns around to its write phase at the same address, no arbitration.
      w_state_nxt     = S_XCHG_WR;
      w_mem_read_nxt  = 1'b0;
      w_mem_write_nxt = 1'b1;
      w_xchg_nxt      = bus.mem_read_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_starve         <= '0;
      r_xchg           <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_write_data <= w_mem_write_data_nxt;
      r_mem_read       <= w_mem_read_nxt;
      r_mem_write      <= w_mem_write_nxt;
      r_starve         <= w_starve_nxt;
      r_xchg           <= w_xchg_nxt;
    end
  end

  assign bus.mem_address    = r_mem_address;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_write_data = r_mem_write_data;

  // Done strobes follow the memory's wait line within the completing cycle.
  assign bus.fetch_done     = (r_state == S_FETCH_RD) && !bus.mem_wait;
  assign bus.fetch_data     = (r_state == S_FETCH_RD) ? bus.mem_read_data : '0;
  assign bus.data_done      = (r_state inside {S_DATA_RD, S_DATA_WR, S_XCHG_WR}) && !bus.mem_wait;
  assign bus.data_read_data = (r_state == S_DATA_RD) ? bus.mem_read_data :
                              (r_state == S_XCHG_WR) ? r_xchg : '0;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed requests push expected dones,
// a negedge monitor pops and checks them against the DUT outputs and a small memory model.
module tb_memory_port_arbiter;
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t fq[$];
  exp_t dq[$];
  logic [31:0] mem [256];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  memory_port_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  memory_port_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .FETCH_STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(m_if.slave)
  );

  // Word-addressed memory model; reads only return real data while a read strobe is up.
  assign m_if.mem_read_data = m_if.mem_read ? mem[m_if.mem_address[9:2]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[8'h10] = 32'h0000_AAAA;
    forever begin
      @(posedge clock);
      if (!reset && m_if.mem_write && !m_if.mem_wait)
        mem[m_if.mem_address[9:2]] <= m_if.mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_f(input int c, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.rdata = d; e.chk_rd = 1'b1; e.wr = 1'b0; e.wdata = '0;
    fq.push_back(e);
  endtask

  task automatic push_d(input int c, input logic [31:0] a, input logic [31:0] d,
                        input logic chk_rd, input logic wr, input logic [31:0] wd);
    exp_t e;
    e.cyc = c; e.addr = a; e.rdata = d; e.chk_rd = chk_rd; e.wr = wr; e.wdata = wd;
    dq.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_read"},       64'(m_if.mem_read),       64'h0);
    chk({tag, "_mem_write"},      64'(m_if.mem_write),      64'h0);
    chk({tag, "_mem_address"},    64'(m_if.mem_address),    64'h0);
    chk({tag, "_mem_write_data"}, 64'(m_if.mem_write_data), 64'h0);
    chk({tag, "_fetch_done"},     64'(m_if.fetch_done),     64'h0);
    chk({tag, "_data_done"},      64'(m_if.data_done),      64'h0);
    chk({tag, "_fetch_data"},     64'(m_if.fetch_data),     64'h0);
    chk({tag, "_data_read_data"}, 64'(m_if.data_read_data), 64'h0);
  endtask

  // Monitor: every done pops the matching queue and checks timing, address and data.
  always @(negedge clock) begin
    exp_t e;
    if (m_if.fetch_done) begin
      if (fq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fetch_done_unexpected (cycle %0d): got done expected none", cyc);
      end else begin
        e = fq.pop_front();
        chk("fetch_cycle", 64'(cyc),              64'(e.cyc));
        chk("fetch_addr",  64'(m_if.mem_address), 64'(e.addr));
        chk("fetch_data",  64'(m_if.fetch_data),  64'(e.rdata));
      end
    end
    if (m_if.data_done) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL data_done_unexpected (cycle %0d): got done expected none", cyc);
      end else begin
        e = dq.pop_front();
        chk("data_cycle", 64'(cyc),              64'(e.cyc));
        chk("data_addr",  64'(m_if.mem_address), 64'(e.addr));
        chk("data_wr",    64'(m_if.mem_write),   64'(e.wr));
        if (e.chk_rd) chk("data_rdata", 64'(m_if.data_read_data), 64'(e.rdata));
        if (e.wr)     chk("data_wdata", 64'(m_if.mem_write_data), 64'(e.wdata));
      end
    end
  end

  initial begin
    reset = 1'b1;
    m_if.fetch_request = 1'b0; m_if.fetch_address = '0;
    m_if.data_read = 1'b0; m_if.data_write = 1'b0;
    m_if.data_address = '0; m_if.data_write_data = '0;
    m_if.mem_wait = 1'b0;
    tick(); tick(); tick();
    @(negedge clock);
    chk_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Single fetch from Idle
    m_if.fetch_request = 1'b1; m_if.fetch_address = 32'h100;
    push_f(cyc + 1, 32'h100, 32'hC0DE_0040);
    tick();
    @(negedge clock);
    chk("t1_mem_read", 64'(m_if.mem_read), 64'h1);
    tick();
    m_if.fetch_request = 1'b0;
    tick(); tick();

    // Simultaneous ld and fetch: data first, fetch right behind
    m_if.data_read = 1'b1; m_if.data_address = 32'h20;
    m_if.fetch_request = 1'b1; m_if.fetch_address = 32'h104;
    push_d(cyc + 1, 32'h20, 32'hC0DE_0008, 1'b1, 1'b0, '0);
    push_f(cyc + 2, 32'h104, 32'hC0DE_0041);
    tick();
    tick();
    m_if.data_read = 1'b0;
    tick();
    m_if.fetch_request = 1'b0;
    @(negedge clock);
    chk("t2_idle_strobes", 64'({m_if.mem_read, m_if.mem_write}), 64'h0);
    tick(); tick();

    // Exchange with a fetch held throughout
    m_if.data_read = 1'b1; m_if.data_write = 1'b1;
    m_if.data_address = 32'h40; m_if.data_write_data = 32'h5555;
    m_if.fetch_request = 1'b1; m_if.fetch_address = 32'h108;
    push_d(cyc + 2, 32'h40, 32'h0000_AAAA, 1'b1, 1'b1, 32'h5555);
    push_f(cyc + 3, 32'h108, 32'hC0DE_0042);
    tick();
    @(negedge clock);
    chk("t3_xchg_rd_strobes", 64'({m_if.mem_read, m_if.mem_write}), 64'h2);
    tick();
    @(negedge clock);
    chk("t3_xchg_wr_strobes", 64'({m_if.mem_read, m_if.mem_write}), 64'h1);
    tick();
    m_if.data_read = 1'b0; m_if.data_write = 1'b0;
    tick();
    m_if.fetch_request = 1'b0;
    tick();
    chk("t3_mem_written", 64'(mem[8'h10]), 64'h5555);

    // ld back the exchanged word
    m_if.data_read = 1'b1; m_if.data_address = 32'h40;
    push_d(cyc + 1, 32'h40, 32'h5555, 1'b1, 1'b0, '0);
    tick(); tick();
    m_if.data_read = 1'b0;
    tick();

    // Store stretched by three wait cycles
    m_if.data_write = 1'b1; m_if.data_address = 32'h80; m_if.data_write_data = 32'h1234_5678;
    push_d(cyc + 4, 32'h80, '0, 1'b0, 1'b1, 32'h1234_5678);
    tick();
    for (int i = 0; i < 4; i++) begin
      m_if.mem_wait = (i < 3);
      @(negedge clock);
      chk("t4_store_hold", {m_if.mem_read, m_if.mem_write, m_if.mem_address, m_if.mem_write_data},
          {2'b01, 32'h80, 32'h1234_5678});
      tick();
    end
    m_if.data_write = 1'b0;
    tick();
    chk("t4_mem_written", 64'(mem[8'h20]), 64'h1234_5678);
    m_if.data_read = 1'b1; m_if.data_address = 32'h80;
    push_d(cyc + 1, 32'h80, 32'h1234_5678, 1'b1, 1'b0, '0);
    tick(); tick();
    m_if.data_read = 1'b0;
    tick();

    // Four data grants over a waiting fetch, then fetch is forced through
    for (int k = 0; k < 4; k++) begin
      m_if.data_read = 1'b1; m_if.data_address = 32'h300 + 32'(4 * k);
      m_if.fetch_request = 1'b1; m_if.fetch_address = 32'h200;
      push_d(cyc + 1, 32'h300 + 32'(4 * k), 32'hC0DE_00C0 + 32'(k), 1'b1, 1'b0, '0);
      tick();
      m_if.fetch_request = 1'b0;
      tick();
    end
    m_if.data_address = 32'h310; m_if.fetch_request = 1'b1;
    push_f(cyc + 1, 32'h200, 32'hC0DE_0080);
    push_d(cyc + 2, 32'h310, 32'hC0DE_00C4, 1'b1, 1'b0, '0);
    tick(); tick();
    m_if.fetch_request = 1'b0;
    tick();
    m_if.data_read = 1'b0;
    tick(); tick();

    // Reset in the middle of a stalled exchange write
    m_if.data_read = 1'b1; m_if.data_write = 1'b1;
    m_if.data_address = 32'h44; m_if.data_write_data = 32'h9999;
    tick();
    tick();
    m_if.mem_wait = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_if.data_read = 1'b0; m_if.data_write = 1'b0; m_if.mem_wait = 1'b0;
    @(negedge clock);
    chk_zero("t6_after_reset");
    tick();
    chk("t6_mem_untouched", 64'(mem[8'h11]), 64'hC0DE_0011);
    m_if.data_read = 1'b1; m_if.data_address = 32'h44;
    push_d(cyc + 1, 32'h44, 32'hC0DE_0011, 1'b1, 1'b0, '0);
    tick(); tick();
    m_if.data_read = 1'b0;
    tick(); tick(); tick();

    chk("fetch_queue_drained", 64'(fq.size()), 64'h0);
    chk("data_queue_drained",  64'(dq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
